// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : instruction_fetch_unit                                            |
// | Brief  : Fetch stage: PC, imem req/ack, IR latch, field decode, branching. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [5:0]  BUBBLE_OP = 6'b111111
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] branch_offset,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  localparam logic [31:0] C_RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic        valid_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] branch_target_d;
  logic [31:0] pc_d;

  assign pc_plus4_d      = pc_q + 32'd4;
  assign branch_target_d = pc_plus4_d + (branch_offset << 2);
  assign pc_d            = (Branch & Zero) ? branch_target_d : pc_plus4_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= C_RESET_PC_ALIGNED;
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_rdata;
            valid_q <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Branch inputs belong to the held instruction; only the release cycle counts.
          if (!stall) begin
            pc_q    <= pc_d;
            ir_q    <= '0;
            valid_q <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_FETCH;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = (state_q == S_FETCH) & ~reset;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_d;
  assign instr_valid = valid_q;

  // Bubble opcode with zeroed fields keeps the decoder's write/memory controls low.
  assign instr  = valid_q ? ir_q          : 32'h0;
  assign opcode = valid_q ? ir_q[31:26]   : BUBBLE_OP;
  assign rs     = valid_q ? ir_q[25:21]   : 5'd0;
  assign rt     = valid_q ? ir_q[20:16]   : 5'd0;
  assign rd     = valid_q ? ir_q[15:11]   : 5'd0;
  assign funct  = valid_q ? ir_q[5:0]     : 6'd0;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_instruction_fetch_unit                                         |
// | Brief  : Vector table plus scoreboard bench for instruction_fetch_unit.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        Branch;
  logic        Zero;
  logic [31:0] branch_offset;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int checks   = 0;
  int failures = 0;

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .BUBBLE_OP(6'b111111)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .Branch       (Branch),
    .Zero         (Zero),
    .branch_offset(branch_offset),
    .stall        (stall),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .opcode       (opcode),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .funct        (funct),
    .pc           (pc),
    .pc_plus4     (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] word;
    int          delay;
    int          stalls;
    logic        br;
    logic        z;
    logic [31:0] off;
    logic [31:0] addr;
    logic [31:0] next;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } sb_t;

  vec_t tbl [11];
  sb_t  sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    sb_t  e;

    // word, ack delay, stall cycles, Branch, Zero, offset, fetch addr, next addr
    tbl[0]  = '{32'h8C08_0004, 0, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004};
    tbl[1]  = '{32'h0109_5020, 0, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    tbl[2]  = '{32'hAC0A_0008, 3, 0, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0008, 32'h0000_000C};
    tbl[3]  = '{32'h2042_0001, 0, 0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_000C, 32'h0000_0010};
    tbl[4]  = '{32'h1000_FFFF, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0010, 32'h0000_0004};
    tbl[5]  = '{32'h1400_0002, 0, 0, 1'b1, 1'b1, 32'h0000_0002, 32'h0000_0004, 32'h0000_0010};
    tbl[6]  = '{32'h1000_FFFF, 0, 0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0010, 32'h0000_0014};
    tbl[7]  = '{32'h0232_8824, 0, 2, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0014, 32'h0000_0018};
    tbl[8]  = '{32'h1000_FFF8, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0000_0018, 32'hFFFF_FFFC};
    tbl[9]  = '{32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[10] = '{32'h3C01_ABCD, 1, 1, 1'b1, 1'b0, 32'h0000_0007, 32'h0000_0000, 32'h0000_0004};

    reset         = 1'b1;
    imem_ack      = 1'b1;
    imem_rdata    = 32'h1234_5678;
    Branch        = 1'b0;
    Zero          = 1'b0;
    branch_offset = 32'h0;
    stall         = 1'b0;

    // Reset held with a live ack: nothing may be requested or latched.
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_req",    {31'd0, imem_req},    32'd0);
      chk("rst_pc",     pc,                   32'd0);
      chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
      chk("rst_opcode", {26'd0, opcode},      32'h3F);
      chk("rst_instr",  instr,                32'd0);
    end
    reset    = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("rel_req",  {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr,         32'd0);

    for (int i = 0; i < 11; i++) begin
      v = tbl[i];
      chk("fetch_req",    {31'd0, imem_req},    32'd1);
      chk("fetch_addr",   imem_addr,            v.addr);
      chk("fetch_valid",  {31'd0, instr_valid}, 32'd0);
      chk("fetch_opcode", {26'd0, opcode},      32'h3F);
      chk("fetch_rs",     {27'd0, rs},          32'd0);
      chk("fetch_funct",  {26'd0, funct},       32'd0);

      for (int d = 0; d < v.delay; d++) begin
        imem_ack = 1'b0;
        step();
        chk("wait_req",   {31'd0, imem_req},    32'd1);
        chk("wait_addr",  imem_addr,            v.addr);
        chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      end

      imem_ack   = 1'b1;
      imem_rdata = v.word;
      sb_q.push_back('{v.word, v.addr});
      step();

      // Ack while executing must be ignored.
      imem_rdata = 32'hDEAD_BEEF;
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("exec_valid",  {31'd0, instr_valid}, 32'd1);
        chk("exec_req",    {31'd0, imem_req},    32'd0);
        chk("exec_instr",  instr,                e.word);
        chk("exec_opcode", {26'd0, opcode},      {26'd0, e.word[31:26]});
        chk("exec_rs",     {27'd0, rs},          {27'd0, e.word[25:21]});
        chk("exec_rt",     {27'd0, rt},          {27'd0, e.word[20:16]});
        chk("exec_rd",     {27'd0, rd},          {27'd0, e.word[15:11]});
        chk("exec_funct",  {26'd0, funct},       {26'd0, e.word[5:0]});
        chk("exec_pc",     pc,                   e.addr);
        chk("exec_pc4",    pc_plus4,             e.addr + 32'd4);

        // Taken-branch inputs during stall must not be sampled.
        for (int s = 0; s < v.stalls; s++) begin
          stall         = 1'b1;
          Branch        = 1'b1;
          Zero          = 1'b1;
          branch_offset = 32'h0000_0100;
          step();
          chk("stall_instr",  instr,                e.word);
          chk("stall_opcode", {26'd0, opcode},      {26'd0, e.word[31:26]});
          chk("stall_pc",     pc,                   e.addr);
          chk("stall_req",    {31'd0, imem_req},    32'd0);
          chk("stall_valid",  {31'd0, instr_valid}, 32'd1);
        end
      end

      stall         = 1'b0;
      imem_ack      = 1'b0;
      Branch        = v.br;
      Zero          = v.z;
      branch_offset = v.off;
      step();
      Branch        = 1'b0;
      Zero          = 1'b0;
      branch_offset = 32'h0;
      chk("next_addr", imem_addr, v.next);
    end

    // Reset colliding with an ack in FETCH discards the returned word.
    chk("r6_pre_addr", imem_addr, 32'h4);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h8C08_0004;
    #1;
    chk("r6_req_gated", {31'd0, imem_req}, 32'd0);
    step();
    chk("r6_valid",  {31'd0, instr_valid}, 32'd0);
    chk("r6_pc",     pc,                   32'd0);
    chk("r6_opcode", {26'd0, opcode},      32'h3F);
    chk("r6_instr",  instr,                32'd0);
    reset    = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("r6_rel_req",  {31'd0, imem_req}, 32'd1);
    chk("r6_rel_addr", imem_addr,         32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
